// File: rtl/uart_tx_scheduler.sv
// Round-robin share of one UART transmitter: req_ready at T+1 and tx_start at T+2 after ARB sees req_valid at T.
// Requesters wait while a frame, its busy/done handshake and the idle gap are in flight; tx_start waits for tx_busy=0.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_en,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(BUSY_TIMEOUT);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);
  // The tx_done cycle itself counts toward the gap, so GAP lasts GAP_CYCLES-1 cycles (at least one).
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
  localparam logic [IW-1:0] LAST_ID  = IW'(NUM_REQ - 1);

  typedef enum logic [2:0] {ARB, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    rr_ptr, rr_ptr_nxt;
  logic [TW-1:0]    to_cnt, to_cnt_nxt;
  logic [GW-1:0]    gap_cnt, gap_cnt_nxt;
  logic             found;
  logic [IW-1:0]    win;
  logic [NUM_REQ-1:0] req_ready_nxt;
  logic             tx_en_nxt, tx_start_nxt, active_nxt, timeout_err_nxt;
  logic [7:0]       tx_data_nxt;
  logic [IW-1:0]    grant_id_nxt;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s -= NUM_REQ;
    return IW'(s);
  endfunction

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[rr_idx(rr_ptr, k)]) begin
        found = 1'b1;
        win   = rr_idx(rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB;
      rr_ptr      <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      req_ready   <= '0;
      tx_en       <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      to_cnt      <= to_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      req_ready   <= req_ready_nxt;
      tx_en       <= tx_en_nxt;
      tx_start    <= tx_start_nxt;
      tx_data     <= tx_data_nxt;
      grant_id    <= grant_id_nxt;
      active      <= active_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:       if (found) state_nxt = LAUNCH;
      LAUNCH:    if (!tx_busy) state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)               state_nxt = WAIT_DONE;
        else if (to_cnt == TO_LAST) state_nxt = GAP;
      end
      WAIT_DONE: if (tx_done) state_nxt = GAP;
      GAP:       if (gap_cnt == GAP_LAST) state_nxt = ARB;
      default:   state_nxt = ARB;
    endcase
  end

  always_comb begin
    req_ready_nxt   = '0;
    tx_start_nxt    = 1'b0;
    tx_en_nxt       = (state_nxt == WAIT_BUSY) || (state_nxt == WAIT_DONE);
    tx_data_nxt     = tx_data;
    grant_id_nxt    = grant_id;
    active_nxt      = active;
    timeout_err_nxt = timeout_err;
    rr_ptr_nxt      = rr_ptr;
    to_cnt_nxt      = '0;
    gap_cnt_nxt     = '0;
    case (state)
      ARB: begin
        if (found) begin
          req_ready_nxt[win] = 1'b1;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == win) tx_data_nxt = req_data[i*8 +: 8];
          end
          grant_id_nxt = win;
          active_nxt   = 1'b1;
          rr_ptr_nxt   = (win == LAST_ID) ? '0 : win + 1'b1;
        end
      end
      LAUNCH:    tx_start_nxt = !tx_busy;
      WAIT_BUSY: begin
        if (!tx_busy) begin
          if (to_cnt == TO_LAST) timeout_err_nxt = 1'b1;
          else                   to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) active_nxt = 1'b0;
        else                     gap_cnt_nxt = gap_cnt + 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a small transmitter model (3-cycle busy, then a done pulse).
module tb_uart_tx_scheduler;
  localparam int NUM_REQ = 4;
  localparam int GAP_CYCLES = 2;
  localparam int BUSY_TIMEOUT = 4;
  localparam int FRAME = 3;

  logic        clk, rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_en, tx_start, tx_busy, tx_done, active, timeout_err;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        model_on, never_busy, m_busy, m_done, f_busy, f_done;

  int tests = 0;
  int fails = 0;

  assign tx_busy = model_on ? m_busy : f_busy;
  assign tx_done = model_on ? m_done : f_done;

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP_CYCLES), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_en(tx_en), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .grant_id(grant_id), .active(active), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for FRAME cycles after a start pulse, then one done cycle.
  initial begin
    m_busy = 1'b0;
    m_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (model_on && tx_start && !never_busy) begin
        m_busy = 1'b1;
        repeat (FRAME) @(posedge clk);
        #1;
        m_busy = 1'b0;
        m_done = 1'b1;
        @(posedge clk); #1;
        m_done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (active !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (active !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: active=%b after %0d cycles, required 0", tag, active, n);
    end
  endtask

  task automatic wait_ready(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (|req_ready) seen = 1'b1;
    end
  endtask

  function automatic int oh2i(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = 32'hFFFF_FFFF;
    tick();
    tick();
    tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL rst_req_ready: got %b required 0000", req_ready); end
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL rst_tx_start: got %b required 0", tx_start); end
    tests++; if (tx_en !== 1'b0) begin fails++; $display("FAIL rst_tx_en: got %b required 0", tx_en); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rst_tx_data: got %h required 00", tx_data); end
    tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL rst_grant_id: got %0d required 0", grant_id); end
    tests++; if (active !== 1'b0) begin fails++; $display("FAIL rst_active: got %b required 0", active); end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL rst_timeout_err: got %b required 0", timeout_err); end
    req_valid = '0;
    rst = 1'b0;
    tick();
    tests++; if (req_ready !== 4'b0 || active !== 1'b0) begin
      fails++; $display("FAIL idle_no_req: req_ready=%b active=%b required 0000/0", req_ready, active);
    end
  endtask

  task automatic test_single_frame();
    bit done_seen = 1'b0;
    int nrdy = 0, nst = 0, bad = 0;
    req_data = 32'h0000_00A5;
    req_valid = 4'b0001;
    tick();
    tests++; if (req_ready !== 4'b0001 || grant_id !== 2'd0 || tx_data !== 8'hA5) begin
      fails++; $display("FAIL sf_accept: req_ready=%b grant=%0d data=%h required 0001/0/a5", req_ready, grant_id, tx_data);
    end
    req_valid = '0;
    tick();
    tests++; if (tx_start !== 1'b1 || tx_en !== 1'b1) begin
      fails++; $display("FAIL sf_start: tx_start=%b tx_en=%b required 1/1", tx_start, tx_en);
    end
    for (int i = 0; i < 40 && !done_seen; i++) begin
      tick();
      if (|req_ready) nrdy++;
      if (tx_start) nst++;
      if (tx_data !== 8'hA5) bad++;
      if (tx_done) done_seen = 1'b1;
    end
    tests++; if (!done_seen) begin fails++; $display("FAIL sf_done: tx_done seen=%b required 1", done_seen); end
    tests++; if (nrdy != 0 || nst != 0) begin
      fails++; $display("FAIL sf_extra_pulses: extra ready=%0d extra start=%0d required 0/0", nrdy, nst);
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL sf_data_stable: %0d cycles off a5, required 0", bad); end
    req_data[7:0] = 8'h5A;
    req_valid = 4'b0001;
    tick();
    tests++; if (active !== 1'b1 || req_ready !== 4'b0) begin
      fails++; $display("FAIL sf_gap: active=%b req_ready=%b required 1/0000", active, req_ready);
    end
    tick();
    tests++; if (active !== 1'b0 || req_ready !== 4'b0) begin
      fails++; $display("FAIL sf_arb: active=%b req_ready=%b required 0/0000", active, req_ready);
    end
    tick();
    tests++; if (req_ready !== 4'b0001 || tx_data !== 8'h5A) begin
      fails++; $display("FAIL sf_next_ready: req_ready=%b data=%h required 0001/5a", req_ready, tx_data);
    end
    req_valid = '0;
    wait_idle("sf");
  endtask

  task automatic test_round_robin();
    int order[5];
    logic [7:0] dat[5];
    int n = 0, gid_bad = 0, exp_b;
    bit oh_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin order[i] = -1; dat[i] = 8'h00; end
    do_reset();
    req_data = 32'h1312_1110;
    req_valid = 4'b1111;
    for (int i = 0; i < 200 && n < 5; i++) begin
      tick();
      if (|req_ready) begin
        if (!$onehot(req_ready)) oh_ok = 1'b0;
        order[n] = oh2i(req_ready);
        dat[n] = tx_data;
        if (grant_id !== 2'(order[n])) gid_bad++;
        n++;
      end
    end
    req_valid = '0;
    tests++; if (n != 5) begin fails++; $display("FAIL rr_count: got %0d grants required 5", n); end
    for (int i = 0; i < 5; i++) begin
      exp_b = 16 + (i % 4);
      tests++;
      if (order[i] != (i % 4) || dat[i] !== 8'(exp_b)) begin
        fails++; $display("FAIL rr_grant[%0d]: got id %0d byte %h required id %0d byte %h", i, order[i], dat[i], i % 4, 8'(exp_b));
      end
    end
    tests++; if (!oh_ok || gid_bad != 0) begin
      fails++; $display("FAIL rr_onehot_grant_id: onehot=%b grant_id mismatches=%0d required 1/0", oh_ok, gid_bad);
    end
    wait_idle("rr");
  endtask

  task automatic test_wrap_skip();
    bit seen;
    int order[2];
    logic [7:0] dat[2];
    int n = 0;
    order[0] = -1; order[1] = -1; dat[0] = 8'h00; dat[1] = 8'h00;
    do_reset();
    req_data = 32'hD3C2_B1A0;
    req_valid = 4'b0100;
    wait_ready(20, seen);
    tests++; if (!seen || req_ready !== 4'b0100) begin
      fails++; $display("FAIL ws_first: seen=%b req_ready=%b required 1/0100", seen, req_ready);
    end
    req_valid = 4'b0101;
    for (int i = 0; i < 100 && n < 2; i++) begin
      tick();
      if (|req_ready) begin
        order[n] = oh2i(req_ready);
        dat[n] = tx_data;
        n++;
      end
    end
    req_valid = '0;
    tests++; if (order[0] != 0 || dat[0] !== 8'hA0) begin
      fails++; $display("FAIL ws_wrap: got id %0d byte %h required id 0 byte a0", order[0], dat[0]);
    end
    tests++; if (order[1] != 2 || dat[1] !== 8'hC2) begin
      fails++; $display("FAIL ws_skip: got id %0d byte %h required id 2 byte c2", order[1], dat[1]);
    end
    wait_idle("ws");
  endtask

  task automatic test_busy_timeout();
    bit seen;
    do_reset();
    never_busy = 1'b1;
    req_data = 32'h0000_8877;
    req_valid = 4'b0001;
    wait_ready(20, seen);
    req_valid = '0;
    tests++; if (!seen) begin fails++; $display("FAIL to_ready: seen=%b required 1", seen); end
    tick();
    tests++; if (tx_start !== 1'b1) begin fails++; $display("FAIL to_start: got %b required 1", tx_start); end
    for (int k = 1; k < BUSY_TIMEOUT; k++) begin
      tick();
      tests++;
      if (timeout_err !== 1'b0 || tx_en !== 1'b1) begin
        fails++; $display("FAIL to_early[%0d]: timeout_err=%b tx_en=%b required 0/1", k, timeout_err, tx_en);
      end
    end
    tick();
    tests++; if (timeout_err !== 1'b1 || tx_en !== 1'b0) begin
      fails++; $display("FAIL to_flag: timeout_err=%b tx_en=%b required 1/0", timeout_err, tx_en);
    end
    never_busy = 1'b0;
    req_valid = 4'b0010;
    wait_ready(20, seen);
    req_valid = '0;
    tests++; if (!seen || req_ready !== 4'b0010 || tx_data !== 8'h88) begin
      fails++; $display("FAIL to_next: seen=%b req_ready=%b data=%h required 1/0010/88", seen, req_ready, tx_data);
    end
    wait_idle("to");
    tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b required 1", timeout_err); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    model_on = 1'b0;
    f_busy = 1'b0;
    f_done = 1'b0;
    req_data = 32'h0000_443C;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    f_busy = 1'b1;
    tick();
    tick();
    tests++; if (active !== 1'b1 || tx_en !== 1'b1 || tx_data !== 8'h3C) begin
      fails++; $display("FAIL rm_in_frame: active=%b tx_en=%b data=%h required 1/1/3c", active, tx_en, tx_data);
    end
    rst = 1'b1;
    tick();
    tests++; if ({req_ready, tx_start, tx_en, tx_data, grant_id, active, timeout_err} !== 17'b0) begin
      fails++; $display("FAIL rm_reset_outputs: rdy=%b st=%b en=%b data=%h gid=%0d act=%b err=%b required all 0",
                        req_ready, tx_start, tx_en, tx_data, grant_id, active, timeout_err);
    end
    rst = 1'b0;
    tick();
    tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL rm_no_spurious: req_ready=%b required 0000", req_ready); end
    req_valid = 4'b0010;
    tick();
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL rm_ready: got %b required 0010", req_ready); end
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (tx_start !== 1'b0 || tx_en !== 1'b0) begin
        fails++; $display("FAIL rm_hold[%0d]: tx_start=%b tx_en=%b required 0/0", k, tx_start, tx_en);
      end
    end
    f_busy = 1'b0;
    f_done = 1'b1;
    tick();
    tests++; if (tx_start !== 1'b1 || tx_data !== 8'h44) begin
      fails++; $display("FAIL rm_launch: tx_start=%b data=%h required 1/44", tx_start, tx_data);
    end
    f_done = 1'b0;
    f_busy = 1'b1;
    tick();
    f_busy = 1'b0;
    f_done = 1'b1;
    tick();
    f_done = 1'b0;
    wait_idle("rm");
  endtask

  task automatic test_start_gating();
    do_reset();
    f_busy = 1'b1;
    req_data = 32'hC300_0000;
    req_valid = 4'b1000;
    tick();
    tests++; if (req_ready !== 4'b1000 || grant_id !== 2'd3) begin
      fails++; $display("FAIL sg_accept: req_ready=%b grant=%0d required 1000/3", req_ready, grant_id);
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (tx_start !== 1'b0) begin fails++; $display("FAIL sg_hold[%0d]: tx_start=%b required 0", k, tx_start); end
    end
    f_busy = 1'b0;
    tick();
    tests++; if (tx_start !== 1'b1 || tx_data !== 8'hC3) begin
      fails++; $display("FAIL sg_pulse: tx_start=%b data=%h required 1/c3", tx_start, tx_data);
    end
    f_busy = 1'b1;
    tick();
    tests++; if (tx_start !== 1'b0 || tx_en !== 1'b1) begin
      fails++; $display("FAIL sg_single: tx_start=%b tx_en=%b required 0/1", tx_start, tx_en);
    end
    f_busy = 1'b0;
    f_done = 1'b1;
    tick();
    f_done = 1'b0;
    wait_idle("sg");
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    model_on = 1'b1;
    never_busy = 1'b0;
    f_busy = 1'b0;
    f_done = 1'b0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_wrap_skip();
    test_busy_timeout();
    test_reset_mid_frame();
    test_start_gating();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
